// File: rtl/mem_pkg.sv
// Shared widths and word/address types for the 32 x 8 test memory.
package mem_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
endpackage : mem_pkg

// File: rtl/mem_ifa.sv
// Signal bundle between the mem_test stimulus block and the memory.
interface mem_ifa
  import mem_pkg::*;
(
  input logic clk
);
  logic  read;
  logic  write;
  addr_t addr;
  data_t data_in;
  data_t data_out;
  logic  rd_valid;
  logic  err;

  modport mem_to_test (
    input  clk, read, write, addr, data_in,
    output data_out, rd_valid, err
  );

  modport test_to_mem (
    input  clk, data_out, rd_valid, err,
    output read, write, addr, data_in
  );
endinterface : mem_ifa

// File: rtl/mem.sv
// Single-port 32 x 8 register-array RAM with registered read, async clear,
// read-valid strobe and a one-cycle error flag for read/write collisions.
module mem
  import mem_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  read,
  input  logic  write,
  input  addr_t addr,
  input  data_t data_in,
  output data_t data_out,
  output logic  rd_valid,
  output logic  err
);

  data_t mem_q [DEPTH];
  data_t dataOut_q, dataOut_d;
  logic  rdValid_q, rdValid_d;
  logic  err_q, err_d;
  logic  wrEn, rdEn;

  // A collision suppresses both the read and the write.
  always_comb begin
    wrEn      = write & ~read;
    rdEn      = read & ~write;
    rdValid_d = rdEn;
    err_d     = read & write;
    dataOut_d = dataOut_q;
    if (rdEn) dataOut_d = mem_q[addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q     <= '{default: '0};
      dataOut_q <= '0;
      rdValid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (wrEn) mem_q[addr] <= data_in;
      dataOut_q <= dataOut_d;
      rdValid_q <= rdValid_d;
      err_q     <= err_d;
    end
  end

  assign data_out = dataOut_q;
  assign rd_valid = rdValid_q;
  assign err      = err_q;

endmodule : mem

// File: tb/tb_mem.sv
// Directed self-checking bench for the 32 x 8 memory.
module tb_mem;
  import mem_pkg::*;

  logic  clk;
  logic  rst_n;
  logic  read;
  logic  write;
  addr_t addr;
  data_t data_in;
  data_t data_out;
  logic  rd_valid;
  logic  err;

  int vectors;
  int miscompares;

  mem dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .read     (read),
    .write    (write),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .rd_valid (rd_valid),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 ns after a rising edge; outputs are sampled 1 ns after the next one.
  task automatic drive_cycle(input logic r, input logic w, input addr_t a, input data_t d);
    read    = r;
    write   = w;
    addr    = a;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    read = 1'b0; write = 1'b0; addr = '0; data_in = '0;
    rst_n = 1'b1;
    #12;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (data_out !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL reset_data_out got %h want 00", data_out);
    end
    vectors++;
    if (rd_valid !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags got rd_valid=%b err=%b want 0 0", rd_valid, err);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      drive_cycle(1'b1, 1'b0, addr_t'(a), 8'h00);
      vectors++;
      if (data_out !== 8'h00 || rd_valid !== 1'b1 || err !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_read[%0d] got data=%h rv=%b err=%b want 00 1 0",
                 a, data_out, rd_valid, err);
      end
    end
  endtask

  task automatic test_fill_and_read();
    for (int a = 0; a < DEPTH; a++) begin
      drive_cycle(1'b0, 1'b1, addr_t'(a), data_t'(a));
      vectors++;
      if (data_out !== 8'h00 || rd_valid !== 1'b0 || err !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL fill_write[%0d] got data=%h rv=%b err=%b want 00 0 0",
                 a, data_out, rd_valid, err);
      end
    end
    for (int a = 0; a < DEPTH; a++) begin
      drive_cycle(1'b1, 1'b0, addr_t'(a), 8'hEE);
      vectors++;
      if (data_out !== data_t'(a) || rd_valid !== 1'b1 || err !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL fill_read[%0d] got data=%h rv=%b err=%b want %h 1 0",
                 a, data_out, rd_valid, err, data_t'(a));
      end
    end
  endtask

  task automatic test_read_after_write();
    drive_cycle(1'b0, 1'b1, 5'h1F, 8'hA5);
    vectors++;
    if (data_out !== 8'h1F || rd_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL raw_write_1f got data=%h rv=%b want 1f 0", data_out, rd_valid);
    end
    drive_cycle(1'b1, 1'b0, 5'h1F, 8'h00);
    vectors++;
    if (data_out !== 8'hA5 || rd_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL raw_read_1f got data=%h rv=%b want a5 1", data_out, rd_valid);
    end
    drive_cycle(1'b0, 1'b1, 5'h00, 8'h5A);
    drive_cycle(1'b1, 1'b0, 5'h00, 8'h00);
    vectors++;
    if (data_out !== 8'h5A || rd_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL raw_read_00 got data=%h rv=%b want 5a 1", data_out, rd_valid);
    end
  endtask

  task automatic test_idle();
    drive_cycle(1'b1, 1'b0, 5'h1F, 8'h00);
    vectors++;
    if (data_out !== 8'hA5) begin
      miscompares++;
      $display("[TB] FAIL idle_setup got %h want a5", data_out);
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b0, addr_t'(i + 3), 8'hFF);
      vectors++;
      if (data_out !== 8'hA5 || rd_valid !== 1'b0 || err !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL idle[%0d] got data=%h rv=%b err=%b want a5 0 0",
                 i, data_out, rd_valid, err);
      end
    end
  endtask

  task automatic test_collision();
    drive_cycle(1'b0, 1'b1, 5'h07, 8'h3C);
    drive_cycle(1'b1, 1'b1, 5'h07, 8'hFF);
    vectors++;
    if (err !== 1'b1 || rd_valid !== 1'b0 || data_out !== 8'hA5) begin
      miscompares++;
      $display("[TB] FAIL collision got err=%b rv=%b data=%h want 1 0 a5",
               err, rd_valid, data_out);
    end
    drive_cycle(1'b0, 1'b0, 5'h00, 8'h00);
    vectors++;
    if (err !== 1'b0 || data_out !== 8'hA5) begin
      miscompares++;
      $display("[TB] FAIL collision_clear got err=%b data=%h want 0 a5", err, data_out);
    end
    drive_cycle(1'b1, 1'b0, 5'h07, 8'h00);
    vectors++;
    if (data_out !== 8'h3C || rd_valid !== 1'b1 || err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL collision_readback got data=%h rv=%b err=%b want 3c 1 0",
               data_out, rd_valid, err);
    end
  endtask

  task automatic test_async_reset();
    drive_cycle(1'b0, 1'b1, 5'h02, 8'h11);
    drive_cycle(1'b1, 1'b0, 5'h02, 8'h00);
    vectors++;
    if (data_out !== 8'h11 || rd_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL areset_setup got data=%h rv=%b want 11 1", data_out, rd_valid);
    end
    read = 1'b0; write = 1'b1; addr = 5'h02; data_in = 8'h99;
    #3;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (data_out !== 8'h00 || rd_valid !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL areset_immediate got data=%h rv=%b err=%b want 00 0 0",
               data_out, rd_valid, err);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    write = 1'b0;
    #1;
    drive_cycle(1'b1, 1'b0, 5'h02, 8'h00);
    vectors++;
    if (data_out !== 8'h00 || rd_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL areset_read_02 got data=%h rv=%b want 00 1", data_out, rd_valid);
    end
    drive_cycle(1'b1, 1'b0, 5'h07, 8'h00);
    vectors++;
    if (data_out !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL areset_read_07 got %h want 00", data_out);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_fill_and_read();
    test_read_after_write();
    test_idle();
    test_collision();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_mem
